// File: rtl/prog_uart_tx.sv
// prog_uart_tx: UART transmitter (8N1, or 8E1 with PROG_UART_TX_PARITY_EN) that
//   serialises WORD_W-bit words LSB byte first, LSB bit first, at a run-time divisor.
// Latency: tx_o drops on the accepting edge; a word takes (WORD_W/8)*10*B cycles
//   (11*B per byte with parity), done_o pulses on the edge the last stop bit ends.
// Backpressure: word_ready_o is high only in IDLE; word_valid_i while busy is ignored
//   and must be held by the source until accepted.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset (forces tx_o high at once)
//   clks_per_bit_i clock cycles per UART bit, sampled at acceptance; 0 behaves as 1
//   word_valid_i   word_i holds a word to send
//   word_i         word to send
//   word_ready_o   block can accept a word this cycle
//   tx_o           serial output, idle high
//   busy_o         a word is in flight
//   done_o         one-cycle pulse when the last stop bit of a word ends
//
// Build option: define PROG_UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit. It must match the receiver's build.

module prog_uart_tx #(
  parameter int DIV_W  = 16,
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DIV_W-1:0]  clks_per_bit_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              word_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int NBYTES = WORD_W / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef PROG_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // Registered state
  state_t            r_state;
  logic [DIV_W-1:0]  r_cnt;      // cycles left in the current bit, minus one
  logic [DIV_W-1:0]  r_bit_m1;   // latched bit time minus one for the word in flight
  logic [2:0]        r_bitcnt;   // data bit index within the byte
  logic [BC_W-1:0]   r_bytecnt;  // byte index within the word
  logic [WORD_W-1:0] r_shift;    // word in flight; current data bit is always bit 0
  logic              r_tx;
  logic              r_done;
`ifdef PROG_UART_TX_PARITY_EN
  logic              r_par;      // running XOR of the data bits already sent
`endif

  // Next-state values
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  w_cnt_nxt;
  logic [DIV_W-1:0]  w_bit_m1_nxt;
  logic [2:0]        w_bitcnt_nxt;
  logic [BC_W-1:0]   w_bytecnt_nxt;
  logic [WORD_W-1:0] w_shift_nxt;
  logic              w_tx_nxt;
  logic              w_done_nxt;
`ifdef PROG_UART_TX_PARITY_EN
  logic              w_par_nxt;
`endif

  logic              w_accept;
  logic              w_bit_end;
  logic [DIV_W-1:0]  w_div_m1;

  assign w_accept  = word_valid_i && (r_state == S_IDLE);
  assign w_bit_end = (r_cnt == '0);
  // A divisor of 0 is treated as 1, so both map to a reload value of 0.
  assign w_div_m1  = (clks_per_bit_i == '0) ? '0 : (clks_per_bit_i - DIV_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_m1  <= '0;
      r_bitcnt  <= '0;
      r_bytecnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
`ifdef PROG_UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_m1  <= w_bit_m1_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_bytecnt <= w_bytecnt_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done_nxt;
`ifdef PROG_UART_TX_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  // tx_o is registered: the value for the next bit is computed here and lands on the
  // same edge the state changes, so each bit lasts exactly B cycles even when B=1.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_m1_nxt  = r_bit_m1;
    w_bitcnt_nxt  = r_bitcnt;
    w_bytecnt_nxt = r_bytecnt;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_done_nxt    = 1'b0;
`ifdef PROG_UART_TX_PARITY_EN
    w_par_nxt     = r_par;
`endif

    unique case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_accept) begin
          w_state_nxt   = S_START;
          w_tx_nxt      = 1'b0;
          w_cnt_nxt     = w_div_m1;
          w_bit_m1_nxt  = w_div_m1;
          w_shift_nxt   = word_i;
          w_bitcnt_nxt  = '0;
          w_bytecnt_nxt = '0;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_nxt  = S_DATA;
          w_tx_nxt     = r_shift[0];
          w_cnt_nxt    = r_bit_m1;
          w_bitcnt_nxt = '0;
`ifdef PROG_UART_TX_PARITY_EN
          w_par_nxt    = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = r_bit_m1;
          // After eight shifts the next byte of the word sits in bits [7:0].
          w_shift_nxt = r_shift >> 1;
`ifdef PROG_UART_TX_PARITY_EN
          w_par_nxt   = r_par ^ r_shift[0];
`endif
          if (r_bitcnt == 3'd7) begin
            w_bitcnt_nxt = '0;
`ifdef PROG_UART_TX_PARITY_EN
            w_state_nxt  = S_PARITY;
            w_tx_nxt     = r_par ^ r_shift[0];
`else
            w_state_nxt  = S_STOP;
            w_tx_nxt     = 1'b1;
`endif
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_tx_nxt     = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end

`ifdef PROG_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
          w_cnt_nxt   = r_bit_m1;
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = r_bit_m1;
          if (r_bytecnt == LAST_BYTE) begin
            w_state_nxt   = S_IDLE;
            w_tx_nxt      = 1'b1;
            w_done_nxt    = 1'b1;
            w_bytecnt_nxt = '0;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            w_state_nxt   = S_START;
            w_tx_nxt      = 1'b0;
            w_bytecnt_nxt = r_bytecnt + BC_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign word_ready_o = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign tx_o         = r_tx;
  assign done_o       = r_done;

endmodule

// File: tb/tb_prog_uart_tx.sv
// Directed-plus-random bench for prog_uart_tx: a reference bit stream is built from
// each word by the UART framing rules and compared with tx_o sampled every cycle.
module tb_prog_uart_tx;

`ifdef PROG_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] clks_per_bit_i = 16'd4;
  logic        word_valid_i = 1'b0;
  logic [31:0] word_i = '0;
  logic        word_ready_o;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_pass   = 0;

  bit exp_q[$];
  bit samp_q[$];

  prog_uart_tx #(.DIV_W(16), .WORD_W(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clks_per_bit_i (clks_per_bit_i),
    .word_valid_i   (word_valid_i),
    .word_i         (word_i),
    .word_ready_o   (word_ready_o),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    assert (got === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
  endtask

  // Reference framing: per byte, start 0, eight data bits LSB first, optional even
  // parity, stop 1.
  task automatic build_stream(input logic [31:0] w);
    logic [7:0] b;
    exp_q.delete();
    for (int j = 0; j < 4; j++) begin
      b = w[8*j +: 8];
      exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
`ifdef PROG_UART_TX_PARITY_EN
      exp_q.push_back(^b);
`endif
      exp_q.push_back(1'b1);
    end
  endtask

  // Sends one word and checks the whole frame. With hold=1, valid stays high so the
  // caller can present the next word immediately after done_o.
  task automatic send(input string tag, input logic [31:0] w, input logic [15:0] div,
                      input logic [15:0] div_after, input bit hold);
    int bt, n, wait_c, mism, early_done, idx;
    logic [7:0] dec;
    bt = (div == 16'd0) ? 1 : int'(div);
    build_stream(w);
    n = exp_q.size() * bt;
    wait_c = 0;
    while (word_ready_o !== 1'b1 && wait_c < 2000) begin
      @(posedge clk_i); #1;
      wait_c++;
    end
    chk({tag, " ready_before"}, word_ready_o, 1);
    word_valid_i   = 1'b1;
    word_i         = w;
    clks_per_bit_i = div;
    @(posedge clk_i); #1;
    if (!hold) word_valid_i = 1'b0;
    clks_per_bit_i = div_after;
    chk({tag, " busy_after_accept"}, busy_o, 1);
    chk({tag, " ready_after_accept"}, word_ready_o, 0);
    samp_q.delete();
    early_done = 0;
    for (int i = 0; i < n; i++) begin
      samp_q.push_back(tx_o);
      if (done_o !== 1'b0) early_done++;
      @(posedge clk_i); #1;
    end
    mism = 0;
    for (int i = 0; i < n; i++) if (samp_q[i] != exp_q[i / bt]) mism++;
    chk({tag, " stream_mismatches"}, mism, 0);
    chk({tag, " early_done"}, early_done, 0);
    chk({tag, " done_at_end"}, done_o, 1);
    chk({tag, " busy_at_end"}, busy_o, 0);
    chk({tag, " ready_at_end"}, word_ready_o, 1);
    chk({tag, " tx_idle_at_end"}, tx_o, 1);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        idx = (j * FB + 1 + k) * bt + bt / 2;
        dec[k] = samp_q[idx];
      end
      chk($sformatf("%s byte%0d", tag, j), dec, w[8*j +: 8]);
`ifdef PROG_UART_TX_PARITY_EN
      idx = (j * FB + 9) * bt + bt / 2;
      chk($sformatf("%s parity%0d", tag, j), samp_q[idx], ^w[8*j +: 8]);
`endif
    end
    if (!hold) begin
      @(posedge clk_i); #1;
      chk({tag, " done_one_cycle"}, done_o, 0);
    end
  endtask

  initial begin
    int bad_tx, bad_rdy, bad_busy, bad_done;
    logic [31:0] rw;
    logic [15:0] rd;

    // Reset, then 100 idle cycles with no valid.
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (tx_o !== 1'b1) bad_tx++;
      if (word_ready_o !== 1'b1) bad_rdy++;
      if (busy_o !== 1'b0) bad_busy++;
      if (done_o !== 1'b0) bad_done++;
    end
    chk("idle tx_bad_cycles", bad_tx, 0);
    chk("idle ready_bad_cycles", bad_rdy, 0);
    chk("idle busy_bad_cycles", bad_busy, 0);
    chk("idle done_bad_cycles", bad_done, 0);

    // B=4, divisor moved to 8 mid-word: frame must stay at B=4 (160 cycles).
    send("b4", 32'h1122_3344, 16'd4, 16'd8, 1'b0);
    // B=1 exact stream, then B=0 must match it.
    send("b1", 32'hA5A5_00FF, 16'd1, 16'd1, 1'b0);
    send("b0", 32'hA5A5_00FF, 16'd0, 16'd3, 1'b0);
    // Back-to-back with valid held high.
    send("b2b_first", 32'hDEAD_BEEF, 16'd3, 16'd3, 1'b1);
    send("b2b_second", 32'h0123_4567, 16'd3, 16'd3, 1'b0);

    // Reset in the middle of byte 2's data bits (all-zero word, so tx is low there).
    word_valid_i = 1'b1; word_i = 32'h0; clks_per_bit_i = 16'd4;
    @(posedge clk_i); #1;
    word_valid_i = 1'b0;
    repeat (95) @(posedge clk_i);
    #1;
    chk("midreset tx_low_before", tx_o, 0);
    chk("midreset busy_before", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset tx_async_high", tx_o, 1);
    chk("midreset busy_cleared", busy_o, 0);
    chk("midreset ready_set", word_ready_o, 1);
    chk("midreset done_low", done_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    bad_done = 0; bad_tx = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (done_o !== 1'b0) bad_done++;
      if (tx_o !== 1'b1) bad_tx++;
    end
    chk("midreset no_done_after", bad_done, 0);
    chk("midreset tx_idle_after", bad_tx, 0);
    send("after_reset", 32'h5A3C_0F81, 16'd2, 16'd2, 1'b0);

`ifdef PROG_UART_TX_PARITY_EN
    // B=2, word 7: parity bits 1,0,0,0 and an 88-cycle word.
    send("parity_b2", 32'h0000_0007, 16'd2, 16'd2, 1'b0);
`endif

    // Random words and divisors (0..5), divisor scrambled after each accept.
    for (int t = 0; t < 5; t++) begin
      rw = $urandom;
      rd = 16'($urandom_range(0, 5));
      send($sformatf("rand%0d", t), rw, rd, 16'($urandom_range(0, 9)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
